audio_playback_fifo: RTL and testbench
======================================

# audio_playback_fifo

Playback sample buffer sitting directly upstream of the DSP/PCM playback serializer in the codec unit, clocked by the codec bit clock. Accepts packed stereo frames (L in [63:32], R in [31:0]) from the sampler/mixer over a valid/ready handshake. Presents the head frame to the serializer's parallel input, and pops one frame per serializer read strobe. Underruns output silence and are counted for software.

## Interface
- ADDR_WIDTH, 4, log2 of FIFO depth (depth = 16 frames)
- ac_bclk  in  1  codec bit clock, sole clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous flush; discards all stored frames
- s_audio_data  in  64  frame from producer: [63:32] left, [31:0] right
- s_audio_valid  in  1  producer frame valid
- s_audio_ready  out  1  FIFO can accept a frame this cycle
- audio_data_out  out  64  head frame to serializer parallel input; zero when empty
- audio_data_rd  in  1  read strobe from serializer (may be high more than one cycle)
- fifo_empty  out  1  no frames stored
- fifo_full  out  1  2^ADDR_WIDTH frames stored
- fifo_level  out  ADDR_WIDTH+1  frames stored
- underrun_count  out  16  saturating count of pops attempted while empty
- underrun_clr  in  1  synchronous clear of underrun_count

## Operation
- Storage: register array of 2^ADDR_WIDTH x 64; write/read pointers ADDR_WIDTH+1 bits wide, MSB distinguishes full from empty; address bits wrap modulo depth.
- Write: accepted on a cycle with s_audio_valid & s_audio_ready; s_audio_ready = ~fifo_full & ~flush & ~rst (combinational). Frame written at wr_ptr, wr_ptr increments.
- Pop detection: rd_q registers audio_data_rd; pop = audio_data_rd & ~rd_q (rising edge). One pop per strobe regardless of strobe width.
- Pop with FIFO non-empty: rd_ptr increments; next head frame becomes visible.
- Pop with FIFO empty: underrun; pointers unchanged; underrun_count increments unless already 0xFFFF (saturates).
- audio_data_out: first-word-fall-through, combinational read of entry rd_ptr, forced to 64'h0 when fifo_empty.
- fifo_level = wr_ptr - rd_ptr (modulo 2^(ADDR_WIDTH+1)); fifo_empty = level==0; fifo_full = level==2^ADDR_WIDTH.
- Simultaneous write and pop, non-empty: both take effect; level unchanged.
- Simultaneous write and pop, empty: write accepted, pop counts as underrun (new frame not yet visible), level becomes 1.
- Full: write blocked by ready; a pop in the same cycle still takes effect (level decrements); producer's frame is accepted next cycle.
- flush: both pointers reset to 0 at the next edge; any concurrent write is refused (ready low) and concurrent pop is ignored (no underrun counted). underrun_count unaffected.
- underrun_clr: count goes to 0 at the next edge; clear wins over a coincident increment.

## Timing
- Reset values: pointers 0, rd_q 0, underrun_count 0; hence audio_data_out 0, fifo_empty 1, fifo_full 0, fifo_level 0, s_audio_ready 0 while rst high, 1 after release.
- Reset asserted mid-operation: all stored frames discarded immediately (asynchronous); memory contents need not be cleared.
- Write-to-output latency: frame written at edge N into an empty FIFO appears on audio_data_out after edge N (cycle N+1).
- Pop latency: pop detected in the cycle audio_data_rd first reads high; rd_ptr advances at that cycle's closing edge; next frame (or zero) visible the following cycle.
- A strobe that stays high for k cycles produces exactly one pop; a new pop requires audio_data_rd low for at least one cycle.
- audio_data_out is stable except at edges where a pop, write-into-empty, flush or reset occurs.

## Test plan
- Reset release, no writes: audio_data_out=0, fifo_empty=1, s_audio_ready=1, level=0; three 1-cycle rd strobes -> underrun_count=3.
- Write 64'hAAAA_0001_5555_0001 into empty FIFO at edge N -> audio_data_out equals it at N+1, level=1; 1-cycle rd -> output 0, level=0, underrun_count unchanged.
- Write 16 frames 1..16 -> fifo_full=1, s_audio_ready=0, level=16; 17th valid held; one pop -> level 15 then 17th accepted; pops read back 1..17 in order, across pointer wrap.
- rd held high 5 cycles with 4 frames stored -> exactly one pop, level 3.
- Empty FIFO, write and rd rising edge same cycle -> underrun_count+1, level=1, frame visible next cycle.
- Force 0xFFFF underruns -> count holds 0xFFFF; underrun_clr coincident with underrun -> count 0; flush with 5 frames and concurrent valid -> level 0, write refused, count unchanged; rst asserted with 5 stored -> level 0 immediately.

Source files
------------

// File: rtl/audio_playback_fifo_if.sv
// Producer-to-playback-FIFO frame handshake: packed stereo frame plus valid/ready.
interface audio_playback_fifo_if;
    logic [63:0] s_audio_data;
    logic        s_audio_valid;
    logic        s_audio_ready;

    modport master (
        output s_audio_data,
        output s_audio_valid,
        input  s_audio_ready
    );

    modport slave (
        input  s_audio_data,
        input  s_audio_valid,
        output s_audio_ready
    );
endinterface

// File: rtl/audio_playback_fifo.sv
// Playback frame FIFO ahead of the PCM serializer: first-word-fall-through head,
// one pop per read-strobe rising edge, saturating underrun counter.
module audio_playback_fifo #(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                    ac_bclk,
    input  logic                    rst,
    input  logic                    flush,
    audio_playback_fifo_if.slave    s_audio,
    output logic [63:0]             audio_data_out,
    input  logic                    audio_data_rd,
    output logic                    fifo_empty,
    output logic                    fifo_full,
    output logic [ADDR_WIDTH:0]     fifo_level,
    output logic [15:0]             underrun_count,
    input  logic                    underrun_clr
);
    localparam int unsigned Depth = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FullLevel = (ADDR_WIDTH + 1)'(Depth);
    localparam logic [ADDR_WIDTH:0] PtrOne = (ADDR_WIDTH + 1)'(1);

    logic [63:0]         mem [Depth];
    logic [ADDR_WIDTH:0] wr_ptr_q;
    logic [ADDR_WIDTH:0] rd_ptr_q;
    logic                rd_q;
    logic [15:0]         underrun_q;

    logic push;
    logic pop;
    logic pop_ok;
    logic underrun;

    always_comb begin
        fifo_level     = wr_ptr_q - rd_ptr_q;
        fifo_empty     = (fifo_level == '0);
        fifo_full      = (fifo_level == FullLevel);
        s_audio.s_audio_ready = ~fifo_full & ~flush & ~rst;
        push           = s_audio.s_audio_valid & s_audio.s_audio_ready;
        // Pop only on the strobe's rising edge; a flush swallows it entirely.
        pop            = audio_data_rd & ~rd_q;
        pop_ok         = pop & ~fifo_empty & ~flush;
        underrun       = pop & fifo_empty & ~flush;
        audio_data_out = fifo_empty ? 64'h0 : mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        underrun_count = underrun_q;
    end

    always_ff @(posedge ac_bclk) begin
        if (push) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= s_audio.s_audio_data;
        end
    end

    always_ff @(posedge ac_bclk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_q       <= 1'b0;
            underrun_q <= '0;
        end else begin
            rd_q <= audio_data_rd;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PtrOne;
                end
                if (pop_ok) begin
                    rd_ptr_q <= rd_ptr_q + PtrOne;
                end
            end
            // Clear has priority over a coincident underrun.
            if (underrun_clr) begin
                underrun_q <= '0;
            end else if (underrun && (underrun_q != 16'hFFFF)) begin
                underrun_q <= underrun_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_audio_playback_fifo.sv
// Self-checking bench for audio_playback_fifo: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_audio_playback_fifo;
    logic        ac_bclk;
    logic        rst;
    logic        flush;
    logic [63:0] audio_data_out;
    logic        audio_data_rd;
    logic        fifo_empty;
    logic        fifo_full;
    logic [4:0]  fifo_level;
    logic [15:0] underrun_count;
    logic        underrun_clr;

    audio_playback_fifo_if s_audio ();

    audio_playback_fifo #(.ADDR_WIDTH(4)) dut (
        .ac_bclk        (ac_bclk),
        .rst            (rst),
        .flush          (flush),
        .s_audio        (s_audio),
        .audio_data_out (audio_data_out),
        .audio_data_rd  (audio_data_rd),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fifo_level     (fifo_level),
        .underrun_count (underrun_count),
        .underrun_clr   (underrun_clr)
    );

    initial begin
        ac_bclk = 1'b0;
        forever #5 ac_bclk = ~ac_bclk;
    end

    int total = 0;
    int bad = 0;

    // Reference model: queue of stored frames, underrun count, last strobe level.
    logic [63:0] mq[$];
    int unsigned mcnt;
    bit          mprev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input bit f);
        logic [63:0] exp_out;
        exp_out = (mq.size() > 0) ? mq[0] : 64'h0;
        chk("ready", 64'(s_audio.s_audio_ready), 64'((mq.size() < 16) && !f));
        chk("data_out", audio_data_out, exp_out);
        chk("level", 64'(fifo_level), 64'(mq.size()));
        chk("empty", 64'(fifo_empty), 64'(mq.size() == 0));
        chk("full", 64'(fifo_full), 64'(mq.size() == 16));
        chk("underrun_count", 64'(underrun_count), 64'(mcnt));
    endtask

    task automatic model_step(input bit v, input logic [63:0] d, input bit r,
                              input bit f, input bit c);
        bit pop;
        bit push;
        bit und;
        pop  = r && !mprev;
        push = v && !f && (mq.size() < 16);
        und  = pop && !f && (mq.size() == 0);
        if (f) begin
            mq.delete();
        end else begin
            if (pop && mq.size() > 0) void'(mq.pop_front());
            if (push) mq.push_back(d);
        end
        if (c) mcnt = 0;
        else if (und && mcnt < 65535) mcnt++;
        mprev = r;
    endtask

    // Called at posedge+1: drive, check pre-edge outputs, clock, update model.
    task automatic cycle(input bit v, input logic [63:0] d, input bit r,
                         input bit f, input bit c);
        s_audio.s_audio_valid = v;
        s_audio.s_audio_data  = d;
        audio_data_rd         = r;
        flush                 = f;
        underrun_clr          = c;
        #3;
        check_model(f);
        @(posedge ac_bclk);
        model_step(v, d, r, f, c);
        #1;
    endtask

    typedef struct {
        bit          v;
        logic [63:0] d;
        bit          r;
        bit          f;
        bit          c;
        int          exp_level;
        int          exp_cnt;
        logic [63:0] exp_out;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [63:0] a;
        logic [63:0] x;
        logic [63:0] y;
        a = 64'hAAAA_0001_5555_0001;
        x = 64'h1234_5678_9ABC_DEF0;
        y = 64'hDEAD_BEEF_CAFE_F00D;
        //           v  d     r  f  c  lvl cnt out
        vecs[0]  = '{0, 64'h0, 0, 0, 0, 0, 0, 64'h0};
        vecs[1]  = '{0, 64'h0, 1, 0, 0, 0, 1, 64'h0};
        vecs[2]  = '{0, 64'h0, 0, 0, 0, 0, 1, 64'h0};
        vecs[3]  = '{0, 64'h0, 1, 0, 0, 0, 2, 64'h0};
        vecs[4]  = '{0, 64'h0, 0, 0, 0, 0, 2, 64'h0};
        vecs[5]  = '{0, 64'h0, 1, 0, 0, 0, 3, 64'h0};
        vecs[6]  = '{0, 64'h0, 0, 0, 0, 0, 3, 64'h0};
        vecs[7]  = '{1, a,     0, 0, 0, 1, 3, a};
        vecs[8]  = '{0, 64'h0, 1, 0, 0, 0, 3, 64'h0};
        vecs[9]  = '{0, 64'h0, 0, 0, 0, 0, 3, 64'h0};
        vecs[10] = '{1, x,     1, 0, 0, 1, 4, x};
        vecs[11] = '{0, 64'h0, 0, 0, 0, 1, 4, x};
        vecs[12] = '{0, 64'h0, 0, 0, 1, 1, 0, x};
        vecs[13] = '{1, y,     0, 1, 0, 0, 0, 64'h0};

        rst = 1'b1;
        flush = 1'b0;
        audio_data_rd = 1'b0;
        underrun_clr = 1'b0;
        s_audio.s_audio_valid = 1'b0;
        s_audio.s_audio_data = '0;
        mq.delete();
        mcnt = 0;
        mprev = 0;

        // Reset state
        repeat (2) @(posedge ac_bclk);
        #1;
        chk("rst_ready", 64'(s_audio.s_audio_ready), 64'h0);
        chk("rst_empty", 64'(fifo_empty), 64'h1);
        chk("rst_full", 64'(fifo_full), 64'h0);
        chk("rst_level", 64'(fifo_level), 64'h0);
        chk("rst_out", audio_data_out, 64'h0);
        chk("rst_count", 64'(underrun_count), 64'h0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].f, vecs[i].c);
            chk($sformatf("vec%0d_level", i), 64'(fifo_level), 64'(vecs[i].exp_level));
            chk($sformatf("vec%0d_count", i), 64'(underrun_count), 64'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_out", i), audio_data_out, vecs[i].exp_out);
        end

        // Fill to full, pop while full with producer waiting, drain across wrap
        for (int i = 1; i <= 16; i++) cycle(1, 64'(i), 0, 0, 0);
        s_audio.s_audio_valid = 1'b1;
        #1;
        chk("full_flag", 64'(fifo_full), 64'h1);
        chk("full_ready", 64'(s_audio.s_audio_ready), 64'h0);
        chk("full_level", 64'(fifo_level), 64'd16);
        cycle(1, 64'd17, 1, 0, 0);
        chk("pop_while_full_level", 64'(fifo_level), 64'd15);
        cycle(1, 64'd17, 0, 0, 0);
        chk("refill_level", 64'(fifo_level), 64'd16);
        for (int i = 2; i <= 17; i++) begin
            chk($sformatf("readback%0d", i), audio_data_out, 64'(i));
            cycle(0, 64'h0, 1, 0, 0);
            cycle(0, 64'h0, 0, 0, 0);
        end
        chk("drained_empty", 64'(fifo_empty), 64'h1);

        // Long strobe pops exactly once
        for (int i = 0; i < 4; i++) cycle(1, 64'(100 + i), 0, 0, 0);
        repeat (5) cycle(0, 64'h0, 1, 0, 0);
        cycle(0, 64'h0, 0, 0, 0);
        chk("long_strobe_level", 64'(fifo_level), 64'd3);
        chk("long_strobe_head", audio_data_out, 64'd101);
        repeat (3) begin
            cycle(0, 64'h0, 1, 0, 0);
            cycle(0, 64'h0, 0, 0, 0);
        end

        // Saturation: preload the counter near the top, then underrun past it
        force dut.underrun_q = 16'hFFFD;
        #1;
        release dut.underrun_q;
        mcnt = 65533;
        #1;
        chk("preload_count", 64'(underrun_count), 64'hFFFD);
        repeat (4) begin
            cycle(0, 64'h0, 1, 0, 0);
            cycle(0, 64'h0, 0, 0, 0);
        end
        chk("saturated_count", 64'(underrun_count), 64'hFFFF);

        // Flush with 5 stored and a concurrent write
        for (int i = 0; i < 5; i++) cycle(1, 64'(200 + i), 0, 0, 0);
        cycle(1, 64'h55, 1, 1, 0);
        chk("flush_level", 64'(fifo_level), 64'd0);
        chk("flush_out", audio_data_out, 64'h0);
        chk("flush_count", 64'(underrun_count), 64'hFFFF);
        cycle(0, 64'h0, 0, 0, 0);

        // Clear beats a coincident underrun
        cycle(0, 64'h0, 1, 0, 1);
        chk("clr_count", 64'(underrun_count), 64'h0);
        cycle(0, 64'h0, 0, 0, 0);

        // Asynchronous reset with frames stored
        for (int i = 0; i < 5; i++) cycle(1, 64'(300 + i), 0, 0, 0);
        s_audio.s_audio_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_level", 64'(fifo_level), 64'h0);
        chk("async_rst_empty", 64'(fifo_empty), 64'h1);
        chk("async_rst_out", audio_data_out, 64'h0);
        chk("async_rst_ready", 64'(s_audio.s_audio_ready), 64'h0);
        @(posedge ac_bclk);
        #1;
        rst = 1'b0;
        mq.delete();
        mcnt = 0;
        mprev = 0;

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 3) == 0,
                  ($urandom % 64) == 0, ($urandom % 128) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
